// File: rtl/hazard_ctrl.sv
// hazard_ctrl: D-stage hazard controller for the pipelined MIPS core.
// Tracks in-flight register writers across NSTAGE post-D slots (slot 0 = E).
// From these it produces the D stall, the D-stage forward selects and the
// mult/div busy interlock.
module hazard_ctrl #(
  parameter int NSTAGE   = 3,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int TW       = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          d_valid,
  input  logic [4:0]                    d_rs,
  input  logic [4:0]                    d_rt,
  input  logic [TW-1:0]                 d_tuse_rs,
  input  logic [TW-1:0]                 d_tuse_rt,
  input  logic [4:0]                    d_a3,
  input  logic [TW-1:0]                 d_tnew,
  input  logic                          d_md,
  input  logic                          d_is_div,
  input  logic                          d_hilo,
  output logic                          stall,
  output logic [$clog2(NSTAGE+1)-1:0]   fwd_rs_sel,
  output logic [$clog2(NSTAGE+1)-1:0]   fwd_rt_sel,
  output logic                          md_busy,
  output logic                          md_start_e
);

  localparam int SW = $clog2(NSTAGE+1);
  localparam int CW = $clog2(DIV_CYC+1);
  localparam logic [TW-1:0] TU_NONE = {TW{1'b1}};

  logic [4:0]    r_a3   [NSTAGE];
  logic [TW-1:0] r_tnew [NSTAGE];
  logic [CW-1:0] r_cnt;
  logic          r_md_start;

  logic          w_stall_data;
  logic          w_stall_md;
  logic          w_stall;
  logic          w_issue;
  logic [SW-1:0] w_sel_rs;
  logic [SW-1:0] w_sel_rt;

  // Match each source against every slot. The loop runs from the oldest
  // slot down to slot 0, so the nearest writer's select is the one that
  // survives.
  always_comb begin
    w_stall_data = 1'b0;
    w_sel_rs     = '0;
    w_sel_rt     = '0;
    for (int k = NSTAGE-1; k >= 0; k--) begin
      if (r_a3[k] == d_rs && d_rs != 5'd0 && d_tuse_rs != TU_NONE) begin
        if (r_tnew[k] > d_tuse_rs) w_stall_data = 1'b1;
        w_sel_rs = (r_tnew[k] == '0) ? SW'(k+1) : '0;
      end
      if (r_a3[k] == d_rt && d_rt != 5'd0 && d_tuse_rt != TU_NONE) begin
        if (r_tnew[k] > d_tuse_rt) w_stall_data = 1'b1;
        w_sel_rt = (r_tnew[k] == '0) ? SW'(k+1) : '0;
      end
    end
  end

  assign w_stall_md = d_valid && d_hilo && (r_cnt != '0);
  assign w_stall    = w_stall_data | w_stall_md;
  assign w_issue    = d_valid && !w_stall;

  // Advance the writer pipeline every cycle. A stalled or empty D inserts a
  // bubble into E.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSTAGE; i++) begin
        r_a3[i]   <= 5'd0;
        r_tnew[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NSTAGE; i++) begin
        r_a3[i]   <= r_a3[i-1];
        r_tnew[i] <= (r_tnew[i-1] != '0) ? r_tnew[i-1] - TW'(1) : '0;
      end
      r_a3[0]   <= w_issue ? d_a3   : 5'd0;
      r_tnew[0] <= w_issue ? d_tnew : '0;
    end
  end

  // Mult/div occupancy counter. It loads when an md instruction actually
  // leaves D; a stall from any cause therefore blocks the load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_md_start <= 1'b0;
    end else begin
      r_md_start <= w_issue && d_md;
      if (w_issue && d_md)
        r_cnt <= d_is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
      else if (r_cnt != '0)
        r_cnt <= r_cnt - CW'(1);
    end
  end

  assign stall      = w_stall;
  assign fwd_rs_sel = w_sel_rs;
  assign fwd_rt_sel = w_sel_rt;
  assign md_busy    = (r_cnt != '0);
  assign md_start_e = r_md_start;

endmodule
